hit_controller_multi: RTL and testbench

- Parametrised successor of the two-ball hit controller.
- Accumulates per-pixel overlaps during a frame for N balls against borders, M holes and every other ball. At the end of the frame it resolves one ball per cycle and publishes new velocities, hole hits and collision flags.
- Sits between the object drawers (which supply draw requests and pixel coordinates) and the ball movement blocks (which consume the velocity updates).

---
 rtl/hit_pkg.sv | 25 ++
 rtl/ball_border_tracker.sv | 48 ++++
 rtl/hit_controller_multi.sv | 248 ++++++++++++++++++++++++
 tb/tb_hit_controller_multi.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hit_pkg.sv
// rtl/hit_pkg.sv - shared types, constants and saturating negate for the multi-ball hit controller
package hit_pkg;

  localparam int VEL_W   = 11;
  localparam int VEL_MAX = 1023;

  typedef logic signed [VEL_W-1:0] vel_t;

  typedef enum logic [1:0] {ACCUM, RESOLVE, DONE} hit_state_t;

  // Which sides of the ball centre a border pixel was seen on
  typedef struct packed {
    logic l;
    logic r;
    logic t;
    logic b;
  } side_t;

  // Negation that maps the most negative value to +VEL_MAX instead of wrapping
  function automatic vel_t sat_neg(input vel_t v);
    if (v == vel_t'(-VEL_MAX - 1)) return vel_t'(VEL_MAX);
    else                           return -v;
  endfunction

endpackage

// File: rtl/ball_border_tracker.sv
// rtl/ball_border_tracker.sv - per-ball sticky border side flags with a frame snapshot copy
module ball_border_tracker
  import hit_pkg::*;
(
  input  logic  clk,
  input  logic  i_rst,
  input  vel_t  i_cx,
  input  vel_t  i_cy,
  input  vel_t  i_px,
  input  vel_t  i_py,
  input  logic  i_hit,
  input  logic  i_snap,
  output side_t o_acc,
  output side_t o_snap
);

  side_t w_new;
  side_t r_acc;
  side_t r_snap;

  // Classify the current overlapping pixel relative to the ball centre
  always_comb begin
    w_new = '0;
    if (i_hit) begin
      w_new.l = (i_px < i_cx);
      w_new.r = !(i_px < i_cx);
      w_new.t = (i_py < i_cy);
      w_new.b = !(i_py < i_cy);
    end
  end

  // Sticky accumulation; the snapshot strobe hands the frame over and this cycle's pixel starts the next one
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_acc  <= '0;
      r_snap <= '0;
    end else if (i_snap) begin
      r_snap <= r_acc;
      r_acc  <= w_new;
    end else begin
      r_acc  <= r_acc | w_new;
    end
  end

  assign o_acc  = r_acc;
  assign o_snap = r_snap;

endmodule

// File: rtl/hit_controller_multi.sv
// rtl/hit_controller_multi.sv - N-ball hit controller; BALL_PAIR_COL_EN enables ball-ball swap collisions
module hit_controller_multi
  import hit_pkg::*;
#(
  parameter int NUM_BALLS = 2,
  parameter int NUM_HOLES = 6,
  parameter int BALL_SIZE = 16,
  parameter int VEL_W     = hit_pkg::VEL_W
) (
  input  logic                                clk,
  input  logic                                resetN,
  input  logic signed [10:0]                  pixelX,
  input  logic signed [10:0]                  pixelY,
  input  logic                                frameEnd,
  input  logic [NUM_BALLS-1:0]                ballDR,
  input  logic                                bordersDR,
  input  logic [NUM_HOLES-1:0]                holeDR,
  input  logic [NUM_BALLS-1:0][VEL_W-1:0]     ballPosX,
  input  logic [NUM_BALLS-1:0][VEL_W-1:0]     ballPosY,
  input  logic [NUM_BALLS-1:0][VEL_W-1:0]     ballVelX,
  input  logic [NUM_BALLS-1:0][VEL_W-1:0]     ballVelY,
  output logic [NUM_BALLS-1:0][VEL_W-1:0]     ballVelXOut,
  output logic [NUM_BALLS-1:0][VEL_W-1:0]     ballVelYOut,
  output logic [NUM_BALLS-1:0]                ballCollisionOccurred,
  output logic [NUM_BALLS-1:0]                ballHoleHit,
  output logic [NUM_BALLS-1:0][2:0]           ballHoleNum,
  output logic                                resolveDone,
  output logic                                overrunErr
);

  localparam int IDX_W = $clog2(NUM_BALLS);

  hit_state_t                        r_state;
  logic [IDX_W-1:0]                  r_idx;
  logic [NUM_BALLS-1:0][VEL_W-1:0]   r_vx_out;
  logic [NUM_BALLS-1:0][VEL_W-1:0]   r_vy_out;
  logic [NUM_BALLS-1:0]              r_col_out;
  logic [NUM_BALLS-1:0]              r_hole_out;
  logic [NUM_BALLS-1:0][2:0]         r_hnum_out;
  logic                              r_done;
  logic                              r_overrun;

  logic [NUM_BALLS-1:0]              r_hole_acc;
  logic [NUM_BALLS-1:0][2:0]         r_hole_num_acc;
  logic [NUM_BALLS-1:0]              r_hole_snap;
  logic [NUM_BALLS-1:0][2:0]         r_hole_num_snap;

  logic                              w_snap;
  logic                              w_any_hole;
  logic [2:0]                        w_hole_lo;
  side_t                             w_side_acc [NUM_BALLS];
  side_t                             w_side     [NUM_BALLS];
  logic [NUM_BALLS-1:0][VEL_W-1:0]   w_res_vx;
  logic [NUM_BALLS-1:0][VEL_W-1:0]   w_res_vy;
  logic [NUM_BALLS-1:0]              w_res_col;
  logic [NUM_BALLS-1:0]              w_res_hole;
  logic [NUM_BALLS-1:0][2:0]         w_res_hnum;

  // Only a frameEnd seen while accumulating hands the frame over
  assign w_snap     = frameEnd && (r_state == ACCUM);
  assign w_any_hole = |holeDR;

  // Lowest-index hole under the current pixel
  always_comb begin
    w_hole_lo = '0;
    for (int h = NUM_HOLES - 1; h >= 0; h--) begin
      if (holeDR[h]) w_hole_lo = 3'(h);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BALLS; gi++) begin : g_ball
      ball_border_tracker u_border (
        .clk    (clk),
        .i_rst  (resetN),
        .i_cx   (vel_t'(ballPosX[gi]) + vel_t'(BALL_SIZE / 2)),
        .i_cy   (vel_t'(ballPosY[gi]) + vel_t'(BALL_SIZE / 2)),
        .i_px   (vel_t'(pixelX)),
        .i_py   (vel_t'(pixelY)),
        .i_hit  (ballDR[gi] & bordersDR),
        .i_snap (w_snap),
        .o_acc  (w_side_acc[gi]),
        .o_snap (w_side[gi])
      );
    end
  endgenerate

  // Sticky hole flags per ball, remembering the lowest hole index seen this frame
  always_ff @(posedge clk) begin
    if (resetN) begin
      r_hole_acc      <= '0;
      r_hole_num_acc  <= '0;
      r_hole_snap     <= '0;
      r_hole_num_snap <= '0;
    end else begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        if (w_snap) begin
          r_hole_snap[i]     <= r_hole_acc[i];
          r_hole_num_snap[i] <= r_hole_num_acc[i];
          r_hole_acc[i]      <= ballDR[i] & w_any_hole;
          r_hole_num_acc[i]  <= (ballDR[i] & w_any_hole) ? w_hole_lo : 3'd0;
        end else if (ballDR[i] & w_any_hole) begin
          r_hole_acc[i]      <= 1'b1;
          r_hole_num_acc[i]  <= (r_hole_acc[i] && (r_hole_num_acc[i] < w_hole_lo)) ?
                                r_hole_num_acc[i] : w_hole_lo;
        end
      end
    end
  end

`ifdef BALL_PAIR_COL_EN
  logic [NUM_BALLS-1:0][NUM_BALLS-1:0] r_pair_acc;
  logic [NUM_BALLS-1:0][NUM_BALLS-1:0] r_pair_snap;
  logic [NUM_BALLS-1:0][NUM_BALLS-1:0] w_pair_now;

  // Upper-triangle pair overlaps under the current pixel
  always_comb begin
    w_pair_now = '0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      for (int j = i + 1; j < NUM_BALLS; j++) begin
        w_pair_now[i][j] = ballDR[i] & ballDR[j];
      end
    end
  end

  // Sticky pair flags with the same snapshot hand-over as the other flags
  always_ff @(posedge clk) begin
    if (resetN) begin
      r_pair_acc  <= '0;
      r_pair_snap <= '0;
    end else if (w_snap) begin
      r_pair_snap <= r_pair_acc;
      r_pair_acc  <= w_pair_now;
    end else begin
      r_pair_acc  <= r_pair_acc | w_pair_now;
    end
  end
`endif

  // Candidate resolution for every ball; the FSM commits the one at r_idx
  always_comb begin
    vel_t vx;
    vel_t vy;
    logic neg_x;
    logic neg_y;
`ifdef BALL_PAIR_COL_EN
    logic found;
    int   p;
`endif
    w_res_vx   = '0;
    w_res_vy   = '0;
    w_res_col  = '0;
    w_res_hole = '0;
    w_res_hnum = '0;
    for (int k = 0; k < NUM_BALLS; k++) begin
      vx    = vel_t'(ballVelX[k]);
      vy    = vel_t'(ballVelY[k]);
      neg_x = (w_side[k].l && (vx < 0)) || (w_side[k].r && (vx > 0));
      neg_y = (w_side[k].t && (vy < 0)) || (w_side[k].b && (vy > 0));
      w_res_vx[k] = vx;
      w_res_vy[k] = vy;
`ifdef BALL_PAIR_COL_EN
      found = 1'b0;
      p     = 0;
      for (int j = NUM_BALLS - 1; j >= 0; j--) begin
        if ((j != k) && ((j > k) ? r_pair_snap[k][j] : r_pair_snap[j][k])) begin
          found = 1'b1;
          p     = j;
        end
      end
`endif
      if (r_hole_snap[k]) begin
        w_res_vx[k]   = '0;
        w_res_vy[k]   = '0;
        w_res_hole[k] = 1'b1;
        w_res_hnum[k] = r_hole_num_snap[k];
        w_res_col[k]  = 1'b1;
`ifdef BALL_PAIR_COL_EN
      end else if (found) begin
        w_res_vx[k]  = ballVelX[p];
        w_res_vy[k]  = ballVelY[p];
        w_res_col[k] = 1'b1;
`endif
      end else begin
        if (neg_x) w_res_vx[k] = sat_neg(vx);
        if (neg_y) w_res_vy[k] = sat_neg(vy);
        w_res_col[k] = neg_x | neg_y;
      end
    end
  end

  // Frame FSM: accumulate, resolve one ball per cycle, pulse done; overrun is sticky
  always_ff @(posedge clk) begin
    if (resetN) begin
      r_state    <= ACCUM;
      r_idx      <= '0;
      r_vx_out   <= '0;
      r_vy_out   <= '0;
      r_col_out  <= '0;
      r_hole_out <= '0;
      r_hnum_out <= '0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (frameEnd && (r_state != ACCUM)) r_overrun <= 1'b1;
      case (r_state)
        ACCUM: begin
          r_done <= 1'b0;
          if (frameEnd) begin
            r_state <= RESOLVE;
            r_idx   <= '0;
          end
        end
        RESOLVE: begin
          r_vx_out[r_idx]   <= w_res_vx[r_idx];
          r_vy_out[r_idx]   <= w_res_vy[r_idx];
          r_col_out[r_idx]  <= w_res_col[r_idx];
          r_hole_out[r_idx] <= w_res_hole[r_idx];
          r_hnum_out[r_idx] <= w_res_hnum[r_idx];
          if (r_idx == IDX_W'(NUM_BALLS - 1)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= ACCUM;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= ACCUM;
        end
      endcase
    end
  end

  assign ballVelXOut           = r_vx_out;
  assign ballVelYOut           = r_vy_out;
  assign ballCollisionOccurred = r_col_out;
  assign ballHoleHit           = r_hole_out;
  assign ballHoleNum           = r_hnum_out;
  assign resolveDone           = r_done;
  assign overrunErr            = r_overrun;

endmodule

// File: tb/tb_hit_controller_multi.sv
// tb/tb_hit_controller_multi.sv - scoreboard bench for hit_controller_multi
module tb_hit_controller_multi;

  localparam int NB = 2;
  localparam int NH = 6;
  localparam int VW = 11;

  logic                       clk = 1'b0;
  logic                       resetN;
  logic signed [10:0]         pixelX;
  logic signed [10:0]         pixelY;
  logic                       frameEnd;
  logic [NB-1:0]              ballDR;
  logic                       bordersDR;
  logic [NH-1:0]              holeDR;
  logic [NB-1:0][VW-1:0]      ballPosX;
  logic [NB-1:0][VW-1:0]      ballPosY;
  logic [NB-1:0][VW-1:0]      ballVelX;
  logic [NB-1:0][VW-1:0]      ballVelY;
  logic [NB-1:0][VW-1:0]      ballVelXOut;
  logic [NB-1:0][VW-1:0]      ballVelYOut;
  logic [NB-1:0]              ballCollisionOccurred;
  logic [NB-1:0]              ballHoleHit;
  logic [NB-1:0][2:0]         ballHoleNum;
  logic                       resolveDone;
  logic                       overrunErr;

  hit_controller_multi #(
    .NUM_BALLS (NB),
    .NUM_HOLES (NH),
    .BALL_SIZE (16),
    .VEL_W     (VW)
  ) dut (
    .clk                   (clk),
    .resetN                (resetN),
    .pixelX                (pixelX),
    .pixelY                (pixelY),
    .frameEnd              (frameEnd),
    .ballDR                (ballDR),
    .bordersDR             (bordersDR),
    .holeDR                (holeDR),
    .ballPosX              (ballPosX),
    .ballPosY              (ballPosY),
    .ballVelX              (ballVelX),
    .ballVelY              (ballVelY),
    .ballVelXOut           (ballVelXOut),
    .ballVelYOut           (ballVelYOut),
    .ballCollisionOccurred (ballCollisionOccurred),
    .ballHoleHit           (ballHoleHit),
    .ballHoleNum           (ballHoleNum),
    .resolveDone           (resolveDone),
    .overrunErr            (overrunErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int vx0; int vy0; int vx1; int vy1;
    int c0;  int c1;  int h0;  int h1;  int n0; int n1;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ball(input int b, input int px, input int py, input int vx, input int vy);
    ballPosX[b] = 11'(px);
    ballPosY[b] = 11'(py);
    ballVelX[b] = 11'(vx);
    ballVelY[b] = 11'(vy);
  endtask

  task automatic pix(input logic [NB-1:0] bdr, input logic bord, input logic [NH-1:0] hdr,
                     input int x, input int y);
    ballDR    = bdr;
    bordersDR = bord;
    holeDR    = hdr;
    pixelX    = 11'(x);
    pixelY    = 11'(y);
    tick();
    ballDR    = '0;
    bordersDR = 1'b0;
    holeDR    = '0;
  endtask

  task automatic push_exp(input int vx0, input int vy0, input int vx1, input int vy1,
                          input int c0, input int c1, input int h0, input int h1,
                          input int n0, input int n1);
    exp_t e;
    e.vx0 = vx0; e.vy0 = vy0; e.vx1 = vx1; e.vy1 = vy1;
    e.c0 = c0; e.c1 = c1; e.h0 = h0; e.h1 = h1; e.n0 = n0; e.n1 = n1;
    exp_q.push_back(e);
  endtask

  // Pulse frameEnd, optionally repeat it one cycle later together with a ball1
  // border pixel, then wait for resolveDone and compare against the scoreboard
  task automatic run_frame(input string tag, input bit dbl);
    exp_t e;
    int   lat;
    frameEnd = 1'b1;
    tick();
    lat = 1;
    frameEnd = dbl;
    if (dbl) begin
      ballDR    = 2'b10;
      bordersDR = 1'b1;
      pixelX    = 11'sd310;
      pixelY    = 11'sd210;
    end
    while (!resolveDone && lat < 12) begin
      tick();
      frameEnd  = 1'b0;
      ballDR    = '0;
      bordersDR = 1'b0;
      lat++;
    end
    if (!resolveDone) begin
      check({tag, "_done_timeout"}, 0, 1);
    end else begin
      check({tag, "_latency"}, lat, NB + 1);
      if (exp_q.size() == 0) begin
        check({tag, "_sb_empty"}, 0, 1);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_v0x"}, $signed(ballVelXOut[0]), e.vx0);
        check({tag, "_v0y"}, $signed(ballVelYOut[0]), e.vy0);
        check({tag, "_v1x"}, $signed(ballVelXOut[1]), e.vx1);
        check({tag, "_v1y"}, $signed(ballVelYOut[1]), e.vy1);
        check({tag, "_col0"}, int'(ballCollisionOccurred[0]), e.c0);
        check({tag, "_col1"}, int'(ballCollisionOccurred[1]), e.c1);
        check({tag, "_hole0"}, int'(ballHoleHit[0]), e.h0);
        check({tag, "_hole1"}, int'(ballHoleHit[1]), e.h1);
        check({tag, "_hnum0"}, int'(ballHoleNum[0]), e.n0);
        check({tag, "_hnum1"}, int'(ballHoleNum[1]), e.n1);
      end
      tick();
      check({tag, "_done_pulse"}, int'(resolveDone), 0);
    end
  endtask

  initial begin
    int seen;
    resetN    = 1'b1;
    pixelX    = '0;
    pixelY    = '0;
    frameEnd  = 1'b0;
    ballDR    = '0;
    bordersDR = 1'b0;
    holeDR    = '0;
    ballPosX  = '0;
    ballPosY  = '0;
    ballVelX  = '0;
    ballVelY  = '0;
    repeat (3) tick();
    resetN = 1'b0;

    check("rst_velx", int'(ballVelXOut), 0);
    check("rst_vely", int'(ballVelYOut), 0);
    check("rst_col", int'(ballCollisionOccurred), 0);
    check("rst_hole", int'(ballHoleHit), 0);
    check("rst_hnum", int'(ballHoleNum), 0);
    check("rst_done", int'(resolveDone), 0);
    check("rst_overrun", int'(overrunErr), 0);

    // Frame A: ball0 left/top border; ball1 holes 5 then 4 plus border, hole wins
    set_ball(0, 100, 100, -3, 2);
    set_ball(1, 300, 200, 4, -5);
    pix(2'b01, 1'b1, 6'b000000, 100, 104);
    pix(2'b10, 1'b0, 6'b100000, 305, 205);
    pix(2'b10, 1'b1, 6'b010000, 310, 210);
    push_exp(3, 2, 0, 0, 1, 1, 0, 1, 0, 4);
    run_frame("fa", 1'b0);

    // Frame B: overlapping balls
    set_ball(0, 100, 100, 5, 0);
    set_ball(1, 300, 200, -2, 1);
    pix(2'b11, 1'b0, 6'b000000, 200, 150);
`ifdef BALL_PAIR_COL_EN
    push_exp(-2, 1, 5, 0, 1, 1, 0, 0, 0, 0);
`else
    push_exp(5, 0, -2, 1, 0, 0, 0, 0, 0, 0);
`endif
    run_frame("fb", 1'b0);

    // Frame C: saturating negate on ball0, right/bottom bounce on ball1
    set_ball(0, 100, 100, -1024, 0);
    set_ball(1, 300, 200, 7, 3);
    pix(2'b01, 1'b1, 6'b000000, 100, 104);
    pix(2'b10, 1'b1, 6'b000000, 310, 210);
    push_exp(1023, 0, -7, -3, 1, 1, 0, 0, 0, 0);
    run_frame("fc", 1'b0);

    // Frame D: hole 0 on ball0, second frameEnd during resolve
    set_ball(0, 100, 100, 2, 2);
    set_ball(1, 300, 200, 1, 1);
    pix(2'b01, 1'b0, 6'b000001, 104, 104);
    push_exp(0, 0, 1, 1, 1, 0, 1, 0, 0, 0);
    run_frame("fd", 1'b1);
    check("overrun_set", int'(overrunErr), 1);

    // Frame E: only the border pixel accumulated during frame D's resolve
    push_exp(2, 2, -1, -1, 0, 1, 0, 0, 0, 0);
    run_frame("fe", 1'b0);
    check("overrun_sticky", int'(overrunErr), 1);

    // Reset while resolving ball 1
    set_ball(0, 100, 100, 9, 9);
    set_ball(1, 300, 200, 6, 6);
    frameEnd = 1'b1;
    tick();
    frameEnd = 1'b0;
    tick();
    check("pre_rst_v0x", $signed(ballVelXOut[0]), 9);
    resetN = 1'b1;
    tick();
    resetN = 1'b0;
    check("midrst_velx", int'(ballVelXOut), 0);
    check("midrst_vely", int'(ballVelYOut), 0);
    check("midrst_col", int'(ballCollisionOccurred), 0);
    check("midrst_done", int'(resolveDone), 0);
    check("midrst_overrun", int'(overrunErr), 0);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (resolveDone) seen++;
    end
    check("midrst_no_done", seen, 0);

    // Frame F: normal operation after reset, hole 5 on ball1
    set_ball(0, 100, 100, 4, 4);
    set_ball(1, 300, 200, -6, 2);
    pix(2'b10, 1'b0, 6'b100000, 305, 205);
    push_exp(4, 4, 0, 0, 0, 1, 0, 1, 0, 5);
    run_frame("ff", 1'b0);

    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
